// File: rtl/layer_output_collector_if.sv
// Handshake bundle between a neuron layer, the output collector and its consumer.
// The collector takes the master view; the producer/consumer side takes the slave view.
interface layer_output_collector_if #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) ();
  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
  logic [NUM_NEURONS-1:0]            in_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_last;
  logic [IDX_WIDTH-1:0]              out_idx;

  modport master (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last, out_idx
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last, out_idx
  );
endinterface

// File: rtl/layer_output_collector.sv
// Gathers one activation word per neuron, then streams the full layer vector word by word.
// Optional ARGMAX_EN macro adds an unsigned argmax over each streamed vector.
module layer_output_collector #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  layer_output_collector_if.master bus,
  output logic                     busy,
  output logic                     err_overrun,
  output logic [IDX_WIDTH-1:0]     class_idx,
  output logic                     class_valid
);

  typedef enum logic [0:0] {StCollect, StStream} state_e;

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  word_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]  word_d [NUM_NEURONS];
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   err_q, err_d;
  logic                   last_word;
  logic [IDX_WIDTH-1:0]   idx_nxt;

  assign last_word = (idx_q == IDX_WIDTH'(NUM_NEURONS - 1));
  assign idx_nxt   = idx_q + IDX_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    word_d     = word_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    unique case (state_q)
      StCollect: begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
          if (bus.in_valid[i]) begin
            word_d[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            mask_d[i] = 1'b1;
          end
        end
        if (|(bus.in_valid & mask_q)) err_d = 1'b1;
        if (&(mask_q | bus.in_valid)) begin
          state_d    = StStream;
          idx_d      = '0;
          // Slot 0 may be captured on this very edge, so take it from the next-state buffer.
          out_data_d = word_d[0];
        end
      end
      StStream: begin
        // Producers are not stalled: anything arriving now is lost.
        if (|bus.in_valid) err_d = 1'b1;
        if (bus.out_ready) begin
          if (last_word) begin
            state_d    = StCollect;
            mask_d     = '0;
            idx_d      = '0;
            out_data_d = '0;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = word_q[idx_nxt];
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StCollect;
      mask_q     <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  // Buffer contents are meaningless until the mask says otherwise, so no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign busy          = (state_q == StStream);
  assign bus.out_valid = busy;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = busy & last_word;
  assign err_overrun   = err_q;

`ifdef ARGMAX_EN
  logic                  accept;
  logic                  take_word;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  max_idx_q;
  logic [IDX_WIDTH-1:0]  class_idx_q;
  logic                  class_valid_q;

  assign accept    = busy & bus.out_ready;
  // Index 0 restarts the search; strict compare keeps the lowest index on ties.
  assign take_word = (idx_q == '0) || (out_data_q > max_q);
  assign best_idx  = take_word ? idx_q : max_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q         <= '0;
      max_idx_q     <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if (accept) begin
        if (take_word) begin
          max_q     <= out_data_q;
          max_idx_q <= idx_q;
        end
        if (last_word) begin
          class_idx_q   <= best_idx;
          class_valid_q <= 1'b1;
        end
      end
    end
  end

  assign class_idx   = class_idx_q;
  assign class_valid = class_valid_q;
`else
  assign class_idx   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed plus randomized bench for layer_output_collector with NUM_NEURONS=4.
module tb_layer_output_collector;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic          clk;
  logic          rst;
  logic          busy;
  logic          err_overrun;
  logic [IW-1:0] class_idx;
  logic          class_valid;

  layer_output_collector_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  layer_output_collector #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_overrun (err_overrun),
    .class_idx   (class_idx),
    .class_valid (class_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  // Reference model: the vector that should be streamed, slots captured so far, sticky error.
  logic [DW-1:0] vec [N];
  logic [N-1:0]  model_mask;
  logic          model_err;
  int            cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned argmax_ref();
    int unsigned best = 0;
    for (int i = 1; i < N; i++) if (vec[i] > vec[best]) best = i;
    return best;
  endfunction

  task automatic capture(input logic [N-1:0] bits, input logic [N*DW-1:0] data);
    bus.in_data  = data;
    bus.in_valid = bits;
    if ((bits & model_mask) != '0) model_err = 1'b1;
    for (int i = 0; i < N; i++) if (bits[i]) vec[i] = data[i*DW +: DW];
    model_mask = model_mask | bits;
    step();
    bus.in_valid = '0;
    chk("cap_out_valid", 64'(bus.out_valid), 64'(&model_mask));
    chk("cap_err", 64'(err_overrun), 64'(model_err));
  endtask

  // mode 0: ready high; 1: stall 3 cycles on index 1; 2: random ready and stray
  // in_valid; 3: ready high with in_valid[2] pulsed on index 1.
  task automatic stream(input int mode, output int cycles);
    int k     = 0;
    int stall = 0;
    logic rdy;
    cycles = 0;
    while (k < N && cycles < 64) begin
      chk("st_valid", 64'(bus.out_valid), 64'd1);
      chk("st_busy", 64'(busy), 64'd1);
      chk("st_data", 64'(bus.out_data), 64'(vec[k]));
      chk("st_idx", 64'(bus.out_idx), 64'(k));
      chk("st_last", 64'(bus.out_last), 64'(k == N - 1));
      chk("st_class_valid", 64'(class_valid), 64'd0);
      rdy = 1'b1;
      if (mode == 1 && k == 1 && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end
      if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
      bus.out_ready = rdy;
      if ((mode == 3 && k == 1) || (mode == 2 && $urandom_range(0, 7) == 0)) begin
        bus.in_valid = (mode == 3) ? 4'b0100 : 4'($urandom_range(1, 15));
        bus.in_data  = {$urandom(), $urandom()};
        model_err    = 1'b1;
      end
      step();
      bus.in_valid = '0;
      cycles++;
      if (rdy) k++;
    end
    chk("st_complete", 64'(k), 64'(N));
    model_mask = '0;
    chk("end_valid", 64'(bus.out_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_err", 64'(err_overrun), 64'(model_err));
`ifdef ARGMAX_EN
    chk("class_pulse", 64'(class_valid), 64'd1);
    chk("class_idx", 64'(class_idx), 64'(argmax_ref()));
    step();
    chk("class_drop", 64'(class_valid), 64'd0);
    chk("class_hold", 64'(class_idx), 64'(argmax_ref()));
`else
    chk("class_off", 64'(class_valid), 64'd0);
    step();
    chk("class_idx_off", 64'(class_idx), 64'd0);
`endif
  endtask

  initial begin
    logic [N-1:0] bits;
    int           guard;
    rst           = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    model_mask    = '0;
    model_err     = 1'b0;
    for (int i = 0; i < N; i++) vec[i] = '0;

    step();
    step();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_idx", 64'(bus.out_idx), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    chk("rst_class_idx", 64'(class_idx), 64'd0);
    chk("rst_class_valid", 64'(class_valid), 64'd0);
    rst = 1'b1;
    step();

    // Basic full capture, no backpressure.
    capture(4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
    stream(0, cyc);
    chk("basic_cycles", 64'(cyc), 64'd4);

    // Staggered capture order 0, 2, 1, 3.
    capture(4'b0001, {$urandom(), $urandom()});
    capture(4'b0100, {$urandom(), $urandom()});
    capture(4'b0010, {$urandom(), $urandom()});
    capture(4'b1000, {$urandom(), $urandom()});
    stream(0, cyc);

    // Backpressure on index 1.
    capture(4'b1111, {$urandom(), $urandom()});
    stream(1, cyc);
    chk("stall_cycles", 64'(cyc), 64'd7);

    // Argmax tie case, and an overrun during streaming.
    capture(4'b1111, {16'h0200, 16'h0300, 16'h0300, 16'h0100});
    stream(3, cyc);
    chk("ovr_stream_sticky", 64'(err_overrun), 64'd1);

    // Reset in the middle of a vector.
    capture(4'b1111, {$urandom(), $urandom()});
    bus.out_ready = 1'b1;
    step();
    step();
    chk("mid_idx", 64'(bus.out_idx), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err_overrun), 64'd0);
    model_mask = '0;
    model_err  = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_class", 64'(class_valid), 64'd0);

    // Double write of slot 0 while collecting: second value wins.
    capture(4'b0001, {$urandom(), $urandom()});
    capture(4'b0001, {$urandom(), $urandom()});
    capture(4'b1110, {$urandom(), $urandom()});
    stream(0, cyc);

    // Randomized vectors with random capture grouping and random backpressure.
    for (int v = 0; v < 8; v++) begin
      guard = 0;
      while (model_mask != '1 && guard < 32) begin
        bits = 4'($urandom_range(0, 15));
        capture(bits, {$urandom(), $urandom()});
        guard++;
      end
      chk("rand_fill", 64'(model_mask), 64'hF);
      stream(2, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
